fip_32_div: RTL and testbench

- Iterative signed fixed-point divider for the ray-tracing datapath. Operands and result use the same Q(WIDTH-FRAC).FRAC format as fip_32_adder and fip_32_sub.
- Computes q = x / y with restoring division, one quotient bit per clock. Its saturation and overflow semantics match the adder and subtractor.
- Sits beside the combinational add/sub units and feeds the intersection and normalisation stages through valid/ready handshakes.

---
 rtl/fip_32_div.sv | 150 +++++++++++++++
 tb/tb_fip_32_div.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fip_32_div.sv
// Iterative signed Q(WIDTH-FRAC).FRAC restoring divider with saturation.
// Define FIP_DIV_ROUND_EN for round-half-away-from-zero via a guard bit.
module fip_32_div #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int N = WIDTH + FRAC;
`ifdef FIP_DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int NI = N + RND;
  localparam int CW = $clog2(NI);

  localparam logic [WIDTH-1:0] QMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] QMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [NI-1:0]   dvd_q;
  logic [NI-1:0]   quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] ay_q;
  logic            sign_q;
  logic            xneg_q;
  logic            yzero_q;

  logic [WIDTH-1:0] ax;
  logic [WIDTH-1:0] ay;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic [WIDTH-1:0] rem_d;
  logic             ge;
  logic [N:0]       qm;
  logic [WIDTH-1:0] mag;
  logic             pos_ovf;
  logic             neg_ovf;

  assign ax = x[WIDTH-1] ? WIDTH'(0) - x : x;
  assign ay = y[WIDTH-1] ? WIDTH'(0) - y : y;

  // remainder stays below |y| <= 2^(WIDTH-1), so only the shifted value needs WIDTH+1 bits
  assign rem_sh  = {rem_q, dvd_q[NI-1]};
  assign ge      = rem_sh[WIDTH] | (rem_sh[WIDTH-1:0] >= ay_q);
  assign rem_sub = rem_sh[WIDTH-1:0] - ay_q;
  assign rem_d   = ge ? rem_sub : rem_sh[WIDTH-1:0];

`ifdef FIP_DIV_ROUND_EN
  assign qm = {1'b0, quo_q[NI-1:1]} + {{N{1'b0}}, quo_q[0]};
`else
  assign qm = {1'b0, quo_q};
`endif

  assign mag     = qm[WIDTH-1:0];
  assign pos_ovf = |qm[N:WIDTH-1];
  assign neg_ovf = (|qm[N:WIDTH]) | (qm[WIDTH-1] & (|qm[WIDTH-2:0]));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      cnt_q       <= '0;
      dvd_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      ay_q        <= '0;
      sign_q      <= 1'b0;
      xneg_q      <= 1'b0;
      yzero_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvd_q    <= {ax, {(FRAC+RND){1'b0}}};
            ay_q     <= ay;
            sign_q   <= x[WIDTH-1] ^ y[WIDTH-1];
            xneg_q   <= x[WIDTH-1];
            yzero_q  <= (y == '0);
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= CW'(NI - 1);
            in_ready <= 1'b0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= {dvd_q[NI-2:0], 1'b0};
          quo_q <= {quo_q[NI-2:0], ge};
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        FIX: begin
          if (yzero_q) begin
            quotient    <= xneg_q ? QMIN : QMAX;
            overflow    <= 1'b0;
            div_by_zero <= 1'b1;
          end else if (sign_q) begin
            quotient    <= neg_ovf ? QMIN : WIDTH'(0) - mag;
            overflow    <= neg_ovf;
            div_by_zero <= 1'b0;
          end else begin
            quotient    <= pos_ovf ? QMAX : mag;
            overflow    <= pos_ovf;
            div_by_zero <= 1'b0;
          end
          out_valid <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fip_32_div.sv
// Self-checking bench for fip_32_div: arithmetic reference model,
// per-cycle output compare, directed vectors, backpressure and reset abort.
module tb_fip_32_div;

  localparam int W = 32;
  localparam int F = 16;
  localparam int N = W + F;
`ifdef FIP_DIV_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  localparam int LAT = N + 1 + int'(RND);

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic        overflow;
  logic        div_by_zero;

  fip_32_div #(.WIDTH(W), .FRAC(F)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .y          (y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .overflow   (overflow),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    logic [31:0] q;
    logic        ovf;
    logic        dz;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  bit   lat_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
  endtask

  // reference: exact integer division on magnitudes, then sign and clamp
  function automatic void model(input logic [31:0] xv, input logic [31:0] yv,
                                output logic [31:0] q, output logic ovf,
                                output logic dz);
    longint sx, sy, ax, ay, qm;
    sx  = longint'($signed(xv));
    sy  = longint'($signed(yv));
    ax  = (sx < 0) ? -sx : sx;
    ay  = (sy < 0) ? -sy : sy;
    ovf = 1'b0;
    dz  = 1'b0;
    if (sy == 0) begin
      dz = 1'b1;
      q  = (sx >= 0) ? 32'h7FFFFFFF : 32'h80000000;
      return;
    end
    if (RND) qm = ((ax * 131072) / ay + 1) / 2;
    else     qm = (ax * 65536) / ay;
    if (xv[31] ^ yv[31]) begin
      if (qm > 64'sd2147483648) begin
        q = 32'h80000000; ovf = 1'b1;
      end else begin
        q = 32'(-qm);
      end
    end else if (qm > 64'sd2147483647) begin
      q = 32'h7FFFFFFF; ovf = 1'b1;
    end else begin
      q = 32'(qm);
    end
  endfunction

  task automatic pin(input string nm, input logic [31:0] xv,
                     input logic [31:0] yv, input logic [31:0] eq,
                     input logic eovf, input logic edz);
    logic [31:0] q;
    logic        o, d;
    model(xv, yv, q, o, d);
    chk({nm, "_q"}, q, eq);
    chk({nm, "_ovf"}, 32'(o), 32'(eovf));
    chk({nm, "_dz"}, 32'(d), 32'(edz));
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!lat_done) begin
          chk("latency", 32'(cyc - exp_q[0].acc), 32'(LAT));
          lat_done = 1'b1;
        end
        chk("quotient", quotient, exp_q[0].q);
        chk("overflow", 32'(overflow), 32'(exp_q[0].ovf));
        chk("div_by_zero", 32'(div_by_zero), 32'(exp_q[0].dz));
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        if (out_ready) begin
          void'(exp_q.pop_front());
          lat_done = 1'b0;
        end
      end
    end
  end

  task automatic op(input logic [31:0] xv, input logic [31:0] yv);
    exp_t e;
    int   k;
    k = 0;
    while (!in_ready && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      return;
    end
    x = xv; y = yv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model(xv, yv, e.q, e.ovf, e.dz);
    e.acc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    lat_done = 1'b0;
  endtask

  logic [31:0] vx [12] = '{32'h00030000, 32'hFFFF0000, 32'h00020000,
                           32'h7FFFFFFF, 32'h80000000, 32'hFFFE0000,
                           32'h00000000, 32'h80000000, 32'h00000000,
                           32'h00010000, 32'h00000001, 32'hFFFB8000};
  logic [31:0] vy [12] = '{32'h00020000, 32'h00040000, 32'h00030000,
                           32'h00000001, 32'h00000001, 32'h00000000,
                           32'h00000000, 32'h00010000, 32'hFFFF0000,
                           32'hFFFF0000, 32'hFFFE0000, 32'hFFFE0000};

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_dz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;

    pin("m_3by2", 32'h00030000, 32'h00020000, 32'h00018000, 1'b0, 1'b0);
    pin("m_m1by4", 32'hFFFF0000, 32'h00040000, 32'hFFFFC000, 1'b0, 1'b0);
    pin("m_2by3", 32'h00020000, 32'h00030000,
        RND ? 32'h0000AAAB : 32'h0000AAAA, 1'b0, 1'b0);
    pin("m_satp", 32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0);
    pin("m_satn", 32'h80000000, 32'h00000001, 32'h80000000, 1'b1, 1'b0);
    pin("m_dzn", 32'hFFFE0000, 32'h00000000, 32'h80000000, 1'b0, 1'b1);
    pin("m_dz0", 32'h00000000, 32'h00000000, 32'h7FFFFFFF, 1'b0, 1'b1);
    pin("m_minexact", 32'h80000000, 32'h00010000, 32'h80000000, 1'b0, 1'b0);
    pin("m_half", 32'h00000001, 32'hFFFE0000,
        RND ? 32'hFFFFFFFF : 32'h00000000, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      op(vx[i], vy[i]);
      wait_done();
    end

    op(32'h00050000, 32'h00020000);
    op(32'hFFF00000, 32'h00030000);
    wait_done();

    out_ready = 1'b0;
    op(32'h00030000, 32'h00020000);
    k = 0;
    while (!out_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    x = 32'h00050000; y = 32'h00010000; in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_q", quotient, 32'h00018000);
    out_ready = 1'b1;
    wait_done();
    repeat (5) @(posedge clk);
    #1;

    op(32'h00030000, 32'h00020000);
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    lat_done = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_quotient", quotient, 32'd0);
    repeat (60) @(posedge clk);
    #1;
    op(32'h00030000, 32'h00020000);
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
